// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl codes, RV32I major opcodes and issue FSM states.
// Used by the ALU, its issue controller and their benches.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_XOR  = 4'd2,
        ALU_ADD  = 4'd3,
        ALU_SUB  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd10,
        ALU_SGE  = 4'd11,
        ALU_SGEU = 4'd12,
        ALU_SEQ  = 4'd13,
        ALU_SNE  = 4'd14,
        ALU_NONE = 4'd15
    } alu_ctrl_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational decode of {opcode, funct3, funct7[5]} into an ALUControl code.
// Unsupported combinations flag illegal and return ALU_NONE.
module alu_op_decoder
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alu_ctrl,
    output logic       illegal
);

    alu_ctrl_e code;

    // NOTE: defaults come first so every path assigns every output and no latch is inferred.
    always_comb begin
        code    = ALU_NONE;
        illegal = 1'b0;
        case (opcode)
            OPC_OP, OPC_OPIMM: begin
                case (funct3)
                    3'b000:  code = (opcode == OPC_OP && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  code = ALU_SLL;
                    3'b010:  code = ALU_SLT;
                    3'b011:  code = ALU_SLTU;
                    3'b100:  code = ALU_XOR;
                    3'b101:  code = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  code = ALU_OR;
                    default: code = ALU_AND;
                endcase
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  code = ALU_SEQ;
                    3'b001:  code = ALU_SNE;
                    3'b100:  code = ALU_SLT;
                    3'b101:  code = ALU_SGE;
                    3'b110:  code = ALU_SLTU;
                    3'b111:  code = ALU_SGEU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LOAD, OPC_STORE, OPC_JALR: code = ALU_ADD;
            default: illegal = 1'b1;
        endcase
    end

    assign alu_ctrl = code;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded RV32I operation at a time to the combinational ALU and returns
// the captured result over a valid/ready response channel.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [6:0]        req_opcode,
    input  logic [2:0]        req_funct3,
    input  logic              req_funct7b5,
    input  logic [DWIDTH-1:0] req_a,
    input  logic [DWIDTH-1:0] req_b,
    output logic [DWIDTH-1:0] SrcA,
    output logic [DWIDTH-1:0] SrcB,
    output logic [3:0]        ALUControl,
    input  logic [DWIDTH-1:0] ALUResult,
    input  logic              Z,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  op_count
);

    state_e     state, state_nxt;
    logic [3:0] code_q;
    logic [3:0] dec_code;
    logic       dec_ill;
    logic       accept;
    logic       handoff;

    alu_op_decoder u_dec (
        .opcode   (req_opcode),
        .funct3   (req_funct3),
        .funct7b5 (req_funct7b5),
        .alu_ctrl (dec_code),
        .illegal  (dec_ill)
    );

    // Status outputs decode straight from state so an async reset clears them at once.
    assign req_ready  = (state == ST_IDLE) & ~rst;
    assign rsp_valid  = (state == ST_RESP);
    assign ALUControl = (state == ST_EXEC) ? code_q : ALU_NONE;
    assign accept     = req_valid & req_ready;
    assign handoff    = rsp_valid & rsp_ready;

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = dec_ill ? ST_RESP : ST_EXEC;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            SrcA       <= '0;
            SrcB       <= '0;
            code_q     <= ALU_NONE;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
            op_count   <= '0;
        end else begin
            if (accept) begin
                SrcA    <= req_a;
                SrcB    <= req_b;
                code_q  <= dec_code;
                rsp_err <= dec_ill;
                // Illegal ops skip EXEC, so their zeroed response is loaded here.
                if (dec_ill) begin
                    rsp_result <= '0;
                    rsp_zero   <= 1'b0;
                end
            end
            if (state == ST_EXEC) begin
                rsp_result <= ALUResult;
                rsp_zero   <= Z;
            end
            if (handoff) op_count <= op_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural ALU, instruction-level reference
// model compared every cycle, plus directed literal cases and randomized traffic.
module tb_alu_issue_ctrl;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [6:0]    req_opcode = '0;
    logic [2:0]    req_funct3 = '0;
    logic          req_funct7b5 = 1'b0;
    logic [DW-1:0] req_a = '0;
    logic [DW-1:0] req_b = '0;
    logic [DW-1:0] SrcA, SrcB, ALUResult;
    logic [3:0]    ALUControl;
    logic          Z;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_result;
    logic          rsp_zero, rsp_err;
    logic [CW-1:0] op_count;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DWIDTH(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_funct3(req_funct3), .req_funct7b5(req_funct7b5),
        .req_a(req_a), .req_b(req_b),
        .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
        .ALUResult(ALUResult), .Z(Z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .op_count(op_count)
    );

    // Behavioural ALU attached to the controller.
    function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a ^ b;
            4'd3:    return a + b;
            4'd4:    return a - b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return $signed(a) >>> b[4:0];
            4'd8:    return 32'($signed(a) < $signed(b));
            4'd10:   return 32'(a < b);
            4'd11:   return 32'($signed(a) >= $signed(b));
            4'd12:   return 32'(a >= b);
            4'd13:   return 32'(a == b);
            4'd14:   return 32'(a != b);
            default: return 32'd0;
        endcase
    endfunction

    assign ALUResult = alu_fn(ALUControl, SrcA, SrcB);
    assign Z         = (ALUResult == 32'd0);

    // Instruction-level expectation: code the controller must issue and the value the
    // instruction computes, from the RV32I meaning of each encoding.
    typedef struct packed {
        logic        ill;
        logic [3:0]  code;
        logic [31:0] res;
    } exp_t;

    function automatic exp_t sem(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                 input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.ill  = 1'b0;
        e.code = 4'd15;
        e.res  = 32'd0;
        case (opc)
            7'b0110011, 7'b0010011: begin
                case (f3)
                    3'd0: if (opc == 7'b0110011 && f7) begin e.code = 4'd4; e.res = a - b; end
                          else begin e.code = 4'd3; e.res = a + b; end
                    3'd1: begin e.code = 4'd5;  e.res = a << b[4:0]; end
                    3'd2: begin e.code = 4'd8;  e.res = 32'($signed(a) < $signed(b)); end
                    3'd3: begin e.code = 4'd10; e.res = 32'(a < b); end
                    3'd4: begin e.code = 4'd2;  e.res = a ^ b; end
                    3'd5: if (f7) begin e.code = 4'd7; e.res = $signed(a) >>> b[4:0]; end
                          else begin e.code = 4'd6; e.res = a >> b[4:0]; end
                    3'd6: begin e.code = 4'd1;  e.res = a | b; end
                    default: begin e.code = 4'd0; e.res = a & b; end
                endcase
            end
            7'b1100011: begin
                case (f3)
                    3'd0: begin e.code = 4'd13; e.res = 32'(a == b); end
                    3'd1: begin e.code = 4'd14; e.res = 32'(a != b); end
                    3'd4: begin e.code = 4'd8;  e.res = 32'($signed(a) < $signed(b)); end
                    3'd5: begin e.code = 4'd11; e.res = 32'($signed(a) >= $signed(b)); end
                    3'd6: begin e.code = 4'd10; e.res = 32'(a < b); end
                    3'd7: begin e.code = 4'd12; e.res = 32'(a >= b); end
                    default: e.ill = 1'b1;
                endcase
            end
            7'b0000011, 7'b0100011, 7'b1100111: begin e.code = 4'd3; e.res = a + b; end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Timeline model: an accepted op at edge cycle m_acc shows its code during the next
    // cycle (legal only) and its response from m_acc+2 (legal) or m_acc+1 (illegal).
    int unsigned cyc = 0;
    int unsigned m_acc = 0;
    int unsigned m_count = 0;
    bit          m_busy = 1'b0;
    exp_t        m_exp = '0;
    logic [31:0] m_a = '0, m_b = '0;
    int unsigned m_rsp_at;
    logic        e_rv;
    logic [3:0]  e_ctl;

    assign m_rsp_at = m_acc + (m_exp.ill ? 1 : 2);
    assign e_rv     = m_busy && (cyc >= m_rsp_at);
    assign e_ctl    = (m_busy && !m_exp.ill && cyc == m_acc + 1) ? m_exp.code : 4'd15;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_count <= 0;
            m_a     <= '0;
            m_b     <= '0;
            m_exp   <= '0;
        end else begin
            cyc <= cyc + 1;
            if (e_rv) begin
                if (rsp_ready) begin
                    m_busy  <= 1'b0;
                    m_count <= (m_count + 1) % (1 << CW);
                end
            end else if (!m_busy && req_valid) begin
                m_busy <= 1'b1;
                m_acc  <= cyc;
                m_a    <= req_a;
                m_b    <= req_b;
                m_exp  <= sem(req_opcode, req_funct3, req_funct7b5, req_a, req_b);
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("m.req_ready", 32'(req_ready), 32'(!m_busy));
            check("m.rsp_valid", 32'(rsp_valid), 32'(e_rv));
            check("m.ALUControl", 32'(ALUControl), 32'(e_ctl));
            check("m.SrcA", SrcA, m_a);
            check("m.SrcB", SrcB, m_b);
            check("m.op_count", 32'(op_count), m_count);
            if (e_rv) begin
                check("m.rsp_result", rsp_result, m_exp.ill ? 32'd0 : m_exp.res);
                check("m.rsp_zero", 32'(rsp_zero), 32'(!m_exp.ill && m_exp.res == 32'd0));
                check("m.rsp_err", 32'(rsp_err), 32'(m_exp.ill));
            end
        end
    end

    // Directed op with literal expectations; leaves rsp_ready high so it completes.
    task automatic do_op(input string nm, input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] ecode,
                         input logic [31:0] eres, input logic ezero, input logic eerr);
        @(negedge clk); #1;
        check({nm, ".idle"}, 32'(req_ready), 32'd1);
        req_opcode = opc; req_funct3 = f3; req_funct7b5 = f7;
        req_a = a; req_b = b; req_valid = 1'b1; rsp_ready = 1'b1;
        @(negedge clk); #1;
        req_valid = 1'b0;
        if (!eerr) begin
            check({nm, ".exec_ctl"}, 32'(ALUControl), 32'(ecode));
            check({nm, ".exec_nrsp"}, 32'(rsp_valid), 32'd0);
            @(negedge clk); #1;
        end
        check({nm, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({nm, ".rsp_ctl"}, 32'(ALUControl), 32'd15);
        check({nm, ".result"}, rsp_result, eres);
        check({nm, ".zero"}, 32'(rsp_zero), 32'(ezero));
        check({nm, ".err"}, 32'(rsp_err), 32'(eerr));
    endtask

    logic [6:0] opcs [6] = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b0000011, 7'b0100011, 7'b1100111};

    initial begin
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.ALUControl", 32'(ALUControl), 32'd15);
        check("rst.op_count", 32'(op_count), 32'd0);
        check("rst.SrcA", SrcA, 32'd0);
        check("rst.req_ready", 32'(req_ready), 32'd0);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        do_op("add",    7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 4'd3, 32'd12, 1'b0, 1'b0);
        do_op("sub",    7'b0110011, 3'b000, 1'b1, 32'd3, 32'd3, 4'd4, 32'd0,  1'b1, 1'b0);
        do_op("addi",   7'b0010011, 3'b000, 1'b1, 32'd3, 32'd3, 4'd3, 32'd6,  1'b0, 1'b0);
        do_op("blt",    7'b1100011, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'd8,  32'd1, 1'b0, 1'b0);
        do_op("bltu",   7'b1100011, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'd10, 32'd0, 1'b1, 1'b0);
        do_op("ill_op", 7'h7F,      3'b000, 1'b0, 32'd9, 32'd9, 4'd15, 32'd0, 1'b0, 1'b1);
        do_op("ill_br", 7'b1100011, 3'b010, 1'b0, 32'd9, 32'd9, 4'd15, 32'd0, 1'b0, 1'b1);

        // Backpressure: seven handoffs so far.
        @(negedge clk); #1;
        req_opcode = 7'b0110011; req_funct3 = 3'b000; req_funct7b5 = 1'b0;
        req_a = 32'd10; req_b = 32'd20; req_valid = 1'b1; rsp_ready = 1'b0;
        @(negedge clk); #1;
        req_valid = 1'b0;
        for (int k = 0; k < 5 && !rsp_valid; k++) begin @(negedge clk); #1; end
        for (int k = 0; k < 4; k++) begin
            check("bp.rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp.result", rsp_result, 32'd30);
            check("bp.req_ready", 32'(req_ready), 32'd0);
            check("bp.op_count", 32'(op_count), 32'd7);
            @(negedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        check("bp.rel_valid", 32'(rsp_valid), 32'd0);
        check("bp.rel_ready", 32'(req_ready), 32'd1);
        check("bp.rel_count", 32'(op_count), 32'd8);

        // Reset while in EXEC.
        req_opcode = 7'b0110011; req_funct3 = 3'b000; req_a = 32'd1; req_b = 32'd2; req_valid = 1'b1;
        @(negedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rx.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rx.ALUControl", 32'(ALUControl), 32'd15);
        check("rx.op_count", 32'(op_count), 32'd0);
        check("rx.SrcA", SrcA, 32'd0);
        @(negedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check("rx.after_ready", 32'(req_ready), 32'd1);
            check("rx.no_stale", 32'(rsp_valid), 32'd0);
        end

        // 2^CW handoffs wrap the counter back to 0.
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a, b;
            a = $urandom; b = $urandom;
            do_op("wrap", 7'b0000011, 3'(i), 1'b0, a, b, 4'd3, a + b, (a + b) == 32'd0, 1'b0);
            @(posedge clk); #1;
            check("wrap.count", 32'(op_count), 32'((i + 1) % 16));
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            req_valid    = ($urandom % 10) < 6;
            rsp_ready    = ($urandom % 10) < 7;
            req_opcode   = ($urandom % 8 < 6) ? opcs[$urandom % 6] : 7'($urandom);
            req_funct3   = 3'($urandom);
            req_funct7b5 = 1'($urandom);
            req_a        = ($urandom % 4 == 0) ? 32'($urandom % 4) : $urandom;
            req_b        = ($urandom % 4 == 0) ? 32'($urandom % 4) : $urandom;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
